// File: rtl/id_ex_stage_pkg.sv
// Shared types/constants for the ID/EX slice.
// ctrl_t is the 12-bit control bundle; CTRL_BUBBLE is its squashed value.
package id_ex_stage_pkg;

  localparam logic [2:0] ALUOP_OTHER  = 3'd0;
  localparam logic [2:0] ALUOP_MEM    = 3'd1;
  localparam logic [2:0] ALUOP_BRANCH = 3'd2;
  localparam logic [2:0] ALUOP_RTYPE  = 3'd3;
  localparam logic [2:0] ALUOP_ITYPE  = 3'd4;
  localparam logic [2:0] ALUOP_LUI    = 3'd5;
  localparam logic [2:0] ALUOP_AUIPC  = 3'd6;
  localparam logic [2:0] ALUOP_JUMP   = 3'd7;

  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPCODE_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic       branch;
    logic       memread;
    logic       memtoreg;
    logic       memwrite;
    logic       alusrc;
    logic       regwrite;
    logic       jalr_jump;
    logic [1:0] regwrite_sel;
    logic [2:0] aluop;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  localparam ctrl_t CTRL_BUBBLE = '{
    branch:       1'b0,
    memread:      1'b0,
    memtoreg:     1'b0,
    memwrite:     1'b0,
    alusrc:       1'b0,
    regwrite:     1'b0,
    jalr_jump:    1'b0,
    regwrite_sel: 2'b00,
    aluop:        ALUOP_OTHER
  };

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// Load-use compare of the EX-held load against the decode sources.
// Ports: ex_* (held load), id_* (decode slot) -> ld_use_o.
module load_use_detect (
  input  logic       ex_valid_i,
  input  logic       ex_memread_i,
  input  logic [4:0] ex_rd_i,
  input  logic       id_valid_i,
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  output logic       ld_use_o
);

  logic src_hit;

  assign src_hit = (ex_rd_i == id_rs1_i) |
                   (ex_rd_i == id_rs2_i);

  assign ld_use_o = ex_valid_i & ex_memread_i &
                    (ex_rd_i != 5'd0) &
                    id_valid_i & src_hit;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble, flush and stall.
// Ports: id_* in, ex_* out, flush_i, stall_i, hazard_stall_o,
// bubble_cnt_o. Macro LOAD_USE_STALL_EN enables hazard logic.
import id_ex_stage_pkg::*;

module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid_i,
  input  logic            id_branch_i,
  input  logic            id_memread_i,
  input  logic            id_memtoreg_i,
  input  logic            id_memwrite_i,
  input  logic            id_alusrc_i,
  input  logic            id_regwrite_i,
  input  logic            id_jalr_jump_i,
  input  logic [1:0]      id_regwrite_sel_i,
  input  logic [2:0]      id_aluop_i,
  input  logic [XLEN-1:0] id_pc_i,
  input  logic [XLEN-1:0] id_rs1_data_i,
  input  logic [XLEN-1:0] id_rs2_data_i,
  input  logic [XLEN-1:0] id_imm_i,
  input  logic [4:0]      id_rs1_i,
  input  logic [4:0]      id_rs2_i,
  input  logic [4:0]      id_rd_i,
  input  logic [2:0]      id_funct3_i,
  input  logic            id_funct7b5_i,
  input  logic            flush_i,
  input  logic            stall_i,
  output logic            ex_valid_o,
  output logic            ex_branch_o,
  output logic            ex_memread_o,
  output logic            ex_memtoreg_o,
  output logic            ex_memwrite_o,
  output logic            ex_alusrc_o,
  output logic            ex_regwrite_o,
  output logic            ex_jalr_jump_o,
  output logic [1:0]      ex_regwrite_sel_o,
  output logic [2:0]      ex_aluop_o,
  output logic [XLEN-1:0] ex_pc_o,
  output logic [XLEN-1:0] ex_rs1_data_o,
  output logic [XLEN-1:0] ex_rs2_data_o,
  output logic [XLEN-1:0] ex_imm_o,
  output logic [4:0]      ex_rs1_o,
  output logic [4:0]      ex_rs2_o,
  output logic [4:0]      ex_rd_o,
  output logic [2:0]      ex_funct3_o,
  output logic            ex_funct7b5_o,
  output logic            hazard_stall_o,
  output logic [CNT_W-1:0] bubble_cnt_o
);

  ctrl_t            ctrl_q, ctrl_d, id_ctrl;
  logic             valid_q, valid_d;
  logic [XLEN-1:0]  pc_q, pc_d, rs1d_q, rs1d_d;
  logic [XLEN-1:0]  rs2d_q, rs2d_d, imm_q, imm_d;
  logic [4:0]       rs1_q, rs1_d, rs2_q, rs2_d;
  logic [4:0]       rd_q, rd_d;
  logic [2:0]       f3_q, f3_d;
  logic             f7_q, f7_d;
  logic             ld_use;

  assign id_ctrl = '{
    branch:       id_branch_i,
    memread:      id_memread_i,
    memtoreg:     id_memtoreg_i,
    memwrite:     id_memwrite_i,
    alusrc:       id_alusrc_i,
    regwrite:     id_regwrite_i,
    jalr_jump:    id_jalr_jump_i,
    regwrite_sel: id_regwrite_sel_i,
    aluop:        id_aluop_i
  };

`ifdef LOAD_USE_STALL_EN
  load_use_detect u_lud (
    .ex_valid_i   (valid_q),
    .ex_memread_i (ctrl_q.memread),
    .ex_rd_i      (rd_q),
    .id_valid_i   (id_valid_i),
    .id_rs1_i     (id_rs1_i),
    .id_rs2_i     (id_rs2_i),
    .ld_use_o     (ld_use)
  );

  logic [CNT_W-1:0] cnt_q;

  assign hazard_stall_o = ld_use & ~flush_i & ~stall_i;

  // Only load-use bubbles count; flush bubbles do not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else if (hazard_stall_o && cnt_q != '1)
      cnt_q <= cnt_q + 1'b1;
  end

  assign bubble_cnt_o = cnt_q;
`else
  assign ld_use         = 1'b0;
  assign hazard_stall_o = 1'b0;
  assign bubble_cnt_o   = '0;
`endif

  always_comb begin
    ctrl_d  = ctrl_q;
    valid_d = valid_q;
    pc_d    = pc_q;
    rs1d_d  = rs1d_q;
    rs2d_d  = rs2d_q;
    imm_d   = imm_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rd_d    = rd_q;
    f3_d    = f3_q;
    f7_d    = f7_q;
    priority case (1'b1)
      flush_i, (!stall_i && ld_use): begin
        ctrl_d  = CTRL_BUBBLE;
        valid_d = 1'b0;
        pc_d    = '0;
        rs1d_d  = '0;
        rs2d_d  = '0;
        imm_d   = '0;
        rs1_d   = '0;
        rs2_d   = '0;
        rd_d    = '0;
        f3_d    = '0;
        f7_d    = 1'b0;
      end
      stall_i: ;
      default: begin
        // Empty decode slot keeps data but never side-effects.
        ctrl_d  = id_valid_i ? id_ctrl : CTRL_BUBBLE;
        valid_d = id_valid_i;
        pc_d    = id_pc_i;
        rs1d_d  = id_rs1_data_i;
        rs2d_d  = id_rs2_data_i;
        imm_d   = id_imm_i;
        rs1_d   = id_rs1_i;
        rs2_d   = id_rs2_i;
        rd_d    = id_rd_i;
        f3_d    = id_funct3_i;
        f7_d    = id_funct7b5_i;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q  <= CTRL_BUBBLE;
      valid_q <= 1'b0;
      pc_q    <= '0;
      rs1d_q  <= '0;
      rs2d_q  <= '0;
      imm_q   <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      f3_q    <= '0;
      f7_q    <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
      pc_q    <= pc_d;
      rs1d_q  <= rs1d_d;
      rs2d_q  <= rs2d_d;
      imm_q   <= imm_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
      f3_q    <= f3_d;
      f7_q    <= f7_d;
    end
  end

  assign ex_valid_o        = valid_q;
  assign ex_branch_o       = ctrl_q.branch;
  assign ex_memread_o      = ctrl_q.memread;
  assign ex_memtoreg_o     = ctrl_q.memtoreg;
  assign ex_memwrite_o     = ctrl_q.memwrite;
  assign ex_alusrc_o       = ctrl_q.alusrc;
  assign ex_regwrite_o     = ctrl_q.regwrite;
  assign ex_jalr_jump_o    = ctrl_q.jalr_jump;
  assign ex_regwrite_sel_o = ctrl_q.regwrite_sel;
  assign ex_aluop_o        = ctrl_q.aluop;
  assign ex_pc_o           = pc_q;
  assign ex_rs1_data_o     = rs1d_q;
  assign ex_rs2_data_o     = rs2d_q;
  assign ex_imm_o          = imm_q;
  assign ex_rs1_o          = rs1_q;
  assign ex_rs2_o          = rs2_q;
  assign ex_rd_o           = rd_q;
  assign ex_funct3_o       = f3_q;
  assign ex_funct7b5_o     = f7_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage.
// Expectations adapt to whether LOAD_USE_STALL_EN is defined.
import id_ex_stage_pkg::*;

module tb_id_ex_stage;

`ifdef LOAD_USE_STALL_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid_i, id_branch_i, id_memread_i;
  logic        id_memtoreg_i, id_memwrite_i, id_alusrc_i;
  logic        id_regwrite_i, id_jalr_jump_i;
  logic [1:0]  id_regwrite_sel_i;
  logic [2:0]  id_aluop_i;
  logic [31:0] id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i;
  logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i;
  logic [2:0]  id_funct3_i;
  logic        id_funct7b5_i, flush_i, stall_i;
  logic        ex_valid_o, ex_branch_o, ex_memread_o;
  logic        ex_memtoreg_o, ex_memwrite_o, ex_alusrc_o;
  logic        ex_regwrite_o, ex_jalr_jump_o;
  logic [1:0]  ex_regwrite_sel_o;
  logic [2:0]  ex_aluop_o;
  logic [31:0] ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o;
  logic [4:0]  ex_rs1_o, ex_rs2_o, ex_rd_o;
  logic [2:0]  ex_funct3_o;
  logic        ex_funct7b5_o, hazard_stall_o;
  logic [15:0] bubble_cnt_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid_i(id_valid_i), .id_branch_i(id_branch_i),
    .id_memread_i(id_memread_i), .id_memtoreg_i(id_memtoreg_i),
    .id_memwrite_i(id_memwrite_i), .id_alusrc_i(id_alusrc_i),
    .id_regwrite_i(id_regwrite_i), .id_jalr_jump_i(id_jalr_jump_i),
    .id_regwrite_sel_i(id_regwrite_sel_i), .id_aluop_i(id_aluop_i),
    .id_pc_i(id_pc_i), .id_rs1_data_i(id_rs1_data_i),
    .id_rs2_data_i(id_rs2_data_i), .id_imm_i(id_imm_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i),
    .id_funct3_i(id_funct3_i), .id_funct7b5_i(id_funct7b5_i),
    .flush_i(flush_i), .stall_i(stall_i),
    .ex_valid_o(ex_valid_o), .ex_branch_o(ex_branch_o),
    .ex_memread_o(ex_memread_o), .ex_memtoreg_o(ex_memtoreg_o),
    .ex_memwrite_o(ex_memwrite_o), .ex_alusrc_o(ex_alusrc_o),
    .ex_regwrite_o(ex_regwrite_o), .ex_jalr_jump_o(ex_jalr_jump_o),
    .ex_regwrite_sel_o(ex_regwrite_sel_o), .ex_aluop_o(ex_aluop_o),
    .ex_pc_o(ex_pc_o), .ex_rs1_data_o(ex_rs1_data_o),
    .ex_rs2_data_o(ex_rs2_data_o), .ex_imm_o(ex_imm_o),
    .ex_rs1_o(ex_rs1_o), .ex_rs2_o(ex_rs2_o), .ex_rd_o(ex_rd_o),
    .ex_funct3_o(ex_funct3_o), .ex_funct7b5_o(ex_funct7b5_o),
    .hazard_stall_o(hazard_stall_o), .bubble_cnt_o(bubble_cnt_o)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic ld,
                       input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] pc);
    id_valid_i        = v;
    id_branch_i       = 1'b0;
    id_memread_i      = ld;
    id_memtoreg_i     = ld;
    id_memwrite_i     = 1'b0;
    id_alusrc_i       = ld;
    id_regwrite_i     = 1'b1;
    id_jalr_jump_i    = 1'b0;
    id_regwrite_sel_i = ld ? 2'b01 : 2'b00;
    id_aluop_i        = ld ? ALUOP_MEM : ALUOP_RTYPE;
    id_pc_i           = pc;
    id_rs1_data_i     = pc + 32'd1;
    id_rs2_data_i     = pc + 32'd2;
    id_imm_i          = ld ? 32'd4 : 32'd0;
    id_rs1_i          = rs1;
    id_rs2_i          = rs2;
    id_rd_i           = rd;
    id_funct3_i       = ld ? 3'b010 : 3'b000;
    id_funct7b5_i     = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n   = 1'b0;
    flush_i = 1'b0;
    stall_i = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
    #1;
    chk("rst_valid", ex_valid_o, 0);
    chk("rst_memread", ex_memread_o, 0);
    chk("rst_regwrite", ex_regwrite_o, 0);
    chk("rst_aluop", ex_aluop_o, ALUOP_OTHER);
    chk("rst_hazard", hazard_stall_o, 0);
    chk("rst_cnt", bubble_cnt_o, 0);
    #10;
    @(negedge clk);
    rst_n = 1'b1;

    // lw x5, 4(x2)
    drive(1'b1, 1'b1, 5'd5, 5'd2, 5'd0, 32'h100);
    step();
    chk("lw_memread", ex_memread_o, 1);
    chk("lw_rd", ex_rd_o, 5);
    chk("lw_valid", ex_valid_o, 1);
    chk("lw_pc", ex_pc_o, 32'h100);
    chk("lw_aluop", ex_aluop_o, ALUOP_MEM);
    chk("lw_hazard", hazard_stall_o, 0);

    // add x6, x5, x1 right behind the load
    drive(1'b1, 1'b0, 5'd6, 5'd5, 5'd1, 32'h104);
    #1;
    chk("lu_hazard", hazard_stall_o, EN);
    step();
    chk("lu_valid", ex_valid_o, !EN);
    chk("lu_regwrite", ex_regwrite_o, !EN);
    chk("lu_rd", ex_rd_o, EN ? 0 : 6);
    chk("lu_cnt", bubble_cnt_o, EN ? 1 : 0);
    chk("lu_hazard_drop", hazard_stall_o, 0);
    step();
    chk("lu_cap_rd", ex_rd_o, 6);
    chk("lu_cap_valid", ex_valid_o, 1);
    chk("lu_cap_rs1d", ex_rs1_data_o, 32'h105);
    chk("lu_cap_aluop", ex_aluop_o, ALUOP_RTYPE);

    // lw x0 followed by a use of x0: never a hazard
    drive(1'b1, 1'b1, 5'd0, 5'd2, 5'd0, 32'h108);
    step();
    drive(1'b1, 1'b0, 5'd7, 5'd0, 5'd0, 32'h10c);
    #1;
    chk("x0_hazard", hazard_stall_o, 0);
    step();
    chk("x0_rd", ex_rd_o, 7);
    chk("x0_valid", ex_valid_o, 1);
    chk("x0_cnt", bubble_cnt_o, EN ? 1 : 0);

    // load-use coinciding with flush
    drive(1'b1, 1'b1, 5'd5, 5'd2, 5'd0, 32'h110);
    step();
    drive(1'b1, 1'b0, 5'd6, 5'd5, 5'd1, 32'h114);
    flush_i = 1'b1;
    #1;
    chk("fl_hazard", hazard_stall_o, 0);
    step();
    flush_i = 1'b0;
    chk("fl_valid", ex_valid_o, 0);
    chk("fl_regwrite", ex_regwrite_o, 0);
    chk("fl_rd", ex_rd_o, 0);
    chk("fl_cnt", bubble_cnt_o, EN ? 1 : 0);

    // external stall with changing decode inputs
    drive(1'b1, 1'b0, 5'd7, 5'd3, 5'd4, 32'h200);
    step();
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 5'(10 + i), 5'd3, 5'd4, 32'h300 + i);
      step();
      chk("st_rd", ex_rd_o, 7);
      chk("st_pc", ex_pc_o, 32'h200);
    end
    stall_i = 1'b0;
    drive(1'b1, 1'b0, 5'd12, 5'd3, 5'd4, 32'h304);
    step();
    chk("st_rel_rd", ex_rd_o, 12);
    chk("st_rel_pc", ex_pc_o, 32'h304);

    // stall masking a load-use, re-evaluated on release
    drive(1'b1, 1'b1, 5'd8, 5'd2, 5'd0, 32'h400);
    step();
    stall_i = 1'b1;
    drive(1'b1, 1'b0, 5'd9, 5'd8, 5'd1, 32'h404);
    #1;
    chk("sl_hazard", hazard_stall_o, 0);
    step();
    chk("sl_hold_rd", ex_rd_o, 8);
    chk("sl_hold_mr", ex_memread_o, 1);
    stall_i = 1'b0;
    #1;
    chk("sl_rel_hazard", hazard_stall_o, EN);
    step();
    chk("sl_valid", ex_valid_o, !EN);
    chk("sl_cnt", bubble_cnt_o, EN ? 2 : 0);
    step();
    chk("sl_cap_rd", ex_rd_o, 9);
    chk("sl_cap_valid", ex_valid_o, 1);

    // empty decode slot: data captured, control squashed
    drive(1'b0, 1'b1, 5'd11, 5'd1, 5'd2, 32'h500);
    step();
    chk("iv_valid", ex_valid_o, 0);
    chk("iv_regwrite", ex_regwrite_o, 0);
    chk("iv_memread", ex_memread_o, 0);
    chk("iv_rd", ex_rd_o, 11);
    chk("iv_pc", ex_pc_o, 32'h500);

    // async reset while stalled
    drive(1'b1, 1'b0, 5'd13, 5'd1, 5'd2, 32'h600);
    step();
    chk("ar_pre_rw", ex_regwrite_o, 1);
    stall_i = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_regwrite", ex_regwrite_o, 0);
    chk("ar_valid", ex_valid_o, 0);
    chk("ar_rd", ex_rd_o, 0);
    chk("ar_cnt", bubble_cnt_o, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
